// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the bcd_conv_arbiter block.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    RESP
  } arb_state_e;

  localparam int unsigned DEF_N       = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DIGITS  = 3;
  localparam int unsigned DEF_TIMEOUT = 64;

  // Width of a requester index / round-robin pointer; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_rr_arb.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
module bcd_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = j;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one multi-cycle binary-to-BCD converter among N requesters, round-robin.
// Optional watchdog on the converter handshake: define BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DIGITS  = DEF_DIGITS,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N*WIDTH-1:0]  req_data,
  output logic [N-1:0]        req_ready,
  output logic [N-1:0]        rsp_valid,
  input  logic [N-1:0]        rsp_ready,
  output logic [DIGITS*4-1:0] rsp_bcd,
  output logic                rsp_err,
  output logic                conv_start,
  output logic [WIDTH-1:0]    conv_bin,
  input  logic                conv_busy,
  input  logic                conv_done,
  input  logic [DIGITS*4-1:0] conv_bcd
);

  localparam int unsigned IW = idx_w(N);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [WIDTH-1:0]    op_q, op_d;
  logic [DIGITS*4-1:0] rsp_q, rsp_d;
  logic [N-1:0]        req_ready_q, req_ready_d;
  logic [N-1:0]        rsp_valid_q, rsp_valid_d;
  logic                conv_start_q, conv_start_d;
  logic [N-1:0]        gidx_oh;

  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          arb_any;

  // Busy is informational only; done alone sequences the handshake.
  logic unused_busy;
  assign unused_busy = conv_busy;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  bcd_rr_arb #(
    .N  (N),
    .IW (IW)
  ) u_rr_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    op_d         = op_q;
    rsp_d        = rsp_q;
    req_ready_d  = '0;
    rsp_valid_d  = rsp_valid_q;
    conv_start_d = conv_start_q;
    gidx_oh      = '0;
    gidx_oh[gidx_q] = 1'b1;
`ifdef BCD_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready_d  = arb_gnt;
          gidx_d       = arb_idx;
          op_d         = req_data[int'(arb_idx)*WIDTH +: WIDTH];
          conv_start_d = 1'b1;
          state_d      = ISSUE;
`ifdef BCD_ARB_TIMEOUT_EN
          cnt_d = '0;
          err_d = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (conv_done) begin
          state_d = SETTLE;
        end
`ifdef BCD_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT)) begin
          state_d      = RESP;
          conv_start_d = 1'b0;
          rsp_d        = '0;
          err_d        = 1'b1;
          rsp_valid_d  = gidx_oh;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SETTLE: begin
        // Start is still high this cycle, so the converter result is valid now.
        rsp_d        = conv_bcd;
        conv_start_d = 1'b0;
        rsp_valid_d  = gidx_oh;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready[gidx_q]) begin
          rsp_valid_d = '0;
          ptr_d       = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      op_q         <= '0;
      rsp_q        <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      conv_start_q <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      op_q         <= op_d;
      rsp_q        <= rsp_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      conv_start_q <= conv_start_d;
`ifdef BCD_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_bcd    = rsp_q;
  assign conv_start = conv_start_q;
  assign conv_bin   = op_q;
`ifdef BCD_ARB_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural converter of programmable latency.
module tb_bcd_conv_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [D*4-1:0] rsp_bcd;
  logic           rsp_err;
  logic           conv_start;
  logic [W-1:0]   conv_bin;
  logic           conv_busy;
  logic           conv_done;
  logic [D*4-1:0] conv_bcd;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(
    .N       (N),
    .WIDTH   (W),
    .DIGITS  (D),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_bcd    (rsp_bcd),
    .rsp_err    (rsp_err),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .conv_busy  (conv_busy),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd)
  );

  // Converter model: done rises lat_cfg edges after start is first seen high,
  // result registered one cycle after done; garbage otherwise.
  int unsigned lat_cfg = 1;
  logic        hang    = 1'b0;
  int unsigned mcnt;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int unsigned x;
    x = v;
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_done <= 1'b0;
      mcnt      <= 0;
      conv_bcd  <= '0;
    end else if (!conv_start) begin
      conv_done <= 1'b0;
      mcnt      <= 0;
      conv_bcd  <= 12'hEEE;
    end else begin
      conv_bcd <= conv_done ? to_bcd(conv_bin) : 12'hEEE;
      if (!conv_done && !hang) begin
        if (mcnt + 1 >= lat_cfg) conv_done <= 1'b1;
        else mcnt <= mcnt + 1;
      end
    end
  end
  assign conv_busy = conv_start && !conv_done;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready high; leaves the DUT in IDLE.
  task automatic run_txn(input logic [3:0] mask, input logic [31:0] data,
                         input int unsigned lat, input int unsigned gi,
                         input logic [11:0] bcd);
    int unsigned cyc;
    lat_cfg   = lat;
    req_data  = data;
    req_valid = mask;
    rsp_ready = '1;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (req_ready == '0 && cyc < 20);
    chk("grant_delay", cyc, 1);
    chk("req_ready", req_ready, 32'(1) << gi);
    chk("conv_start_on", conv_start, 1);
    chk("conv_bin", conv_bin, data[gi*8 +: 8]);
    step();
    chk("req_ready_pulse", req_ready, 0);
    cyc = 1;
    while (rsp_valid == '0 && cyc < 200) begin
      step();
      cyc++;
    end
    req_valid = '0;
    chk("rsp_latency", cyc, lat + 2);
    chk("rsp_valid", rsp_valid, 32'(1) << gi);
    chk("rsp_bcd", rsp_bcd, bcd);
    chk("rsp_err", rsp_err, 0);
    chk("start_low_in_resp", conv_start, 0);
    step();
    chk("rsp_valid_clear", rsp_valid, 0);
    chk("start_low_in_idle", conv_start, 0);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int unsigned lat;
    int unsigned gi;
    logic [11:0] bcd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int unsigned cyc;
    int unsigned ok;

    tbl[0]  = '{4'b1111, {8'd199, 8'd100, 8'd9,  8'd0},   3, 0, 12'h000};
    tbl[1]  = '{4'b1111, {8'd199, 8'd100, 8'd9,  8'd0},   1, 1, 12'h009};
    tbl[2]  = '{4'b1111, {8'd199, 8'd100, 8'd9,  8'd0},   2, 2, 12'h100};
    tbl[3]  = '{4'b1111, {8'd199, 8'd100, 8'd9,  8'd0},   4, 3, 12'h199};
    tbl[4]  = '{4'b0001, {8'd0,   8'd0,   8'd0,  8'd255}, 3, 0, 12'h255};
    tbl[5]  = '{4'b1010, {8'd33,  8'd0,   8'd71, 8'd0},   2, 1, 12'h071};
    tbl[6]  = '{4'b1010, {8'd33,  8'd0,   8'd71, 8'd0},   2, 3, 12'h033};
    tbl[7]  = '{4'b1010, {8'd33,  8'd0,   8'd71, 8'd0},   1, 1, 12'h071};
    tbl[8]  = '{4'b1010, {8'd33,  8'd0,   8'd71, 8'd0},   3, 3, 12'h033};
    tbl[9]  = '{4'b0101, {8'd0,   8'd250, 8'd0,  8'd7},   1, 0, 12'h007};
    tbl[10] = '{4'b0101, {8'd0,   8'd250, 8'd0,  8'd7},   1, 2, 12'h250};
    tbl[11] = '{4'b0011, {8'd0,   8'd0,   8'd64, 8'd128}, 5, 0, 12'h128};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '1;
    step();
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_bcd", rsp_bcd, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_conv_bin", conv_bin, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++)
      run_txn(tbl[i].mask, tbl[i].data, tbl[i].lat, tbl[i].gi, tbl[i].bcd);

    // Response backpressure on requester 2 while everyone else is waiting.
    lat_cfg   = 2;
    req_data  = {8'd8, 8'd77, 8'd0, 8'd0};
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (req_ready == '0 && cyc < 20);
    chk("bp_grant", req_ready, 4'b0100);
    req_valid = 4'b1111;
    cyc = 0;
    while (rsp_valid == '0 && cyc < 50) begin
      step();
      cyc++;
    end
    req_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 4'b0100);
      chk("bp_rsp_bcd", rsp_bcd, 12'h077);
      chk("bp_no_grant", req_ready, 0);
      chk("bp_start_low", conv_start, 0);
      step();
    end
    rsp_ready = '1;
    step();
    chk("bp_released", rsp_valid, 0);
    step();
    chk("bp_next_grant", req_ready, 4'b1000);
    req_valid = '0;
    cyc = 0;
    while (rsp_valid == '0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("bp_next_rsp", rsp_valid, 4'b1000);
    chk("bp_next_bcd", rsp_bcd, 12'h008);
    step();

    // Converter that never completes.
    hang      = 1'b1;
    lat_cfg   = 1;
    req_data  = {8'd0, 8'd0, 8'd123, 8'd0};
    req_valid = 4'b0010;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (req_ready == '0 && cyc < 20);
    chk("hang_grant", req_ready, 4'b0010);
    req_valid = '0;
`ifdef BCD_ARB_TIMEOUT_EN
    cyc = 0;
    while (rsp_valid == '0 && cyc < 60) begin
      step();
      cyc++;
    end
    chk("to_latency", cyc, 17);
    chk("to_rsp_valid", rsp_valid, 4'b0010);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_bcd", rsp_bcd, 0);
    chk("to_start_low", conv_start, 0);
    hang = 1'b0;
    step();
    chk("to_released", rsp_valid, 0);
`else
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (conv_start === 1'b1 && rsp_valid === '0) ok++;
    end
    chk("hang_waits", ok, 40);
    hang = 1'b0;
    cyc = 0;
    while (rsp_valid == '0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("hang_rsp_valid", rsp_valid, 4'b0010);
    chk("hang_rsp_bcd", rsp_bcd, 12'h123);
    chk("hang_rsp_err", rsp_err, 0);
    step();
`endif
    run_txn(4'b0100, {8'd0, 8'd61, 8'd0, 8'd0}, 2, 2, 12'h061);

    // Asynchronous reset in the middle of a conversion.
    lat_cfg   = 30;
    req_data  = {8'd0, 8'd0, 8'd0, 8'd200};
    req_valid = 4'b0001;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (req_ready == '0 && cyc < 20);
    req_valid = '0;
    step();
    step();
    chk("mid_start_high", conv_start, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_start", conv_start, 0);
    chk("mid_rst_bin", conv_bin, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_bcd", rsp_bcd, 0);
    chk("mid_rst_err", rsp_err, 0);
    step();
    rst = 1'b0;
    step();
    run_txn(4'b0001, {8'd0, 8'd0, 8'd0, 8'd42}, 2, 0, 12'h042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares a single multi-cycle binary-to-BCD converter among N requesters. Each requester submits a binary value over a valid/ready handshake. The block grants one requester at a time, runs the converter's level-held start/busy/done protocol, captures the BCD result and returns it to the granted requester. It sits between the display/reporting clients and the one shared converter instance.

## Interface
- `N`, 4: number of requesters (2..16).
- `WIDTH`, 8: binary operand width; must match the converter.
- `DIGITS`, 3: BCD digit count; must match the converter.
- `TIMEOUT`, 64: watchdog limit in cycles (used only with the macro).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N: per-requester request valid.
- `req_data` in N*WIDTH: operands; requester i uses bits [i*WIDTH +: WIDTH].
- `req_ready` out N: one-hot; requester i's operand is accepted this cycle.
- `rsp_valid` out N: one-hot; result is available for requester i.
- `rsp_ready` in N: per-requester result accept.
- `rsp_bcd` out DIGITS*4: result shared by all requesters; qualified by rsp_valid.
- `rsp_err` out 1: timeout flag, qualified by rsp_valid; tied 0 without the macro.
- `conv_start` out 1: converter start, level-held.
- `conv_bin` out WIDTH: converter operand; held stable while conv_start=1.
- `conv_busy` in 1: converter busy (monitor only).
- `conv_done` in 1: converter done; stays high while start is held.
- `conv_bcd` in DIGITS*4: converter result; registered, valid one cycle after conv_done first rises.

## Operation
- The FSM has four states:
  - IDLE: the arbiter picks the next valid requester at or after `ptr`, round-robin. It pulses req_ready[g] for one cycle, latches g and req_data[g] into `op_q`, and goes to ISSUE. If no requester is valid, it stays in IDLE.
  - ISSUE: conv_start=1 and conv_bin=op_q. When conv_done=1, go to SETTLE.
  - SETTLE: conv_start stays 1 for one cycle. conv_bcd is captured into `rsp_q`, and the FSM goes to RESP.
  - RESP: conv_start=0 and rsp_valid[g]=1 with rsp_bcd=rsp_q. When rsp_ready[g]=1, set ptr=g+1 (mod N) and return to IDLE.
- Arbitration happens only in IDLE. Requests that arrive during ISSUE, SETTLE or RESP wait. No requester is granted twice in a row while another requester is valid.
- Outputs are driven from registers: conv_start, conv_bin, req_ready, rsp_valid and rsp_bcd.
- A requester must hold req_valid/req_data until it sees req_ready. It may deassert req_valid afterwards with no effect on the running conversion.
- rsp_ready on non-granted lines is ignored.
- The converter is never restarted until conv_start has been low for at least one cycle. RESP guarantees this.

## Timing
- Reset values: all outputs 0, ptr=0, state IDLE, op_q=0, rsp_q=0.
- A request that is valid in IDLE gets req_ready on the next edge. conv_start rises on the same edge.
- Controller overhead is 1 cycle (grant) + 1 cycle (SETTLE) + at least 1 cycle (RESP). Total latency is converter latency + 3 cycles when rsp_ready is already high.
- Back-to-back: with rsp_ready tied high, one conversion completes per converter-latency + 4 cycles.
- If rst is asserted mid-conversion, everything returns to reset values immediately and conv_start drops. The converter shares rst and also resets.
- If conv_done=1 in the same cycle that ISSUE is entered, it is honoured on the next edge.

## Configuration
- Macro: `BCD_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A counter runs during ISSUE.
  - If the count reaches TIMEOUT without conv_done, the FSM goes to RESP with rsp_bcd=0 and rsp_err=1. conv_start drops there.
  - The counter clears on every entry to ISSUE.
- Without the macro: there is no counter, ISSUE waits indefinitely, and rsp_err is constant 0.

## Structure
- Package `bcd_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, SETTLE, RESP);
  - default parameter constants;
  - the `ptr`/grant index width function.
- Sub-module `bcd_rr_arb` implements the round-robin pick. It is combinational: inputs req[N] and ptr, outputs a one-hot grant and its index plus `any`. The parent FSM registers the result.

## Test plan
The bench uses a behavioural converter model that honours the conv_* protocol with programmable latency.
- Single request: requester 0 sends 8'd255 → one req_ready[0] pulse, conv_start high until SETTLE, rsp_valid[0] with rsp_bcd=12'h255.
- All four requesters valid simultaneously with 0, 9, 100, 199 → grants in order 0,1,2,3 and results 12'h000, 12'h009, 12'h100, 12'h199. conv_start is low for at least 1 cycle between conversions.
- Fairness: requesters 1 and 3 held valid continuously → grants alternate 1,3,1,3.
- Response backpressure: rsp_ready[2] held low 10 cycles → rsp_valid[2] and rsp_bcd stay stable, there is no new grant, and conv_start stays 0.
- Reset mid-conversion: assert rst during ISSUE → all outputs are 0 on the same cycle. After release, a request for 8'd42 returns 12'h042.
- With `BCD_ARB_TIMEOUT_EN` defined and TIMEOUT=16, a model that never asserts done → rsp_valid is high 17 cycles after grant with rsp_err=1 and rsp_bcd=0, and the next requester is served normally.
